serial_div: RTL and testbench
=============================

// Module: serial_div
//
// PURPOSE
//  Serial restoring divider for signed two's-complement operands.
//  Computes quotient and remainder of a/b, one quotient bit per clock cycle.
//  Uses the same start/data_ready handshake as the serial multiplier.
//  Sits next to the multiplier in the datapath, for scaling and normalisation.
//
// PARAMETERS
//  N_BITS_A  8  dividend width, signed; also the quotient width
//  N_BITS_B  8  divisor width, signed; also the remainder width; must be <= N_BITS_A
//
// PORTS
//  reset         input   1         asynchronous, active-low
//  clk           input   1         clock
//  a             input   N_BITS_A  dividend, sampled on start
//  b             input   N_BITS_B  divisor, sampled on start
//  start         input   1         begin division; honoured only while data_ready=1
//  data_ready    output  1         1 = idle/results valid, 0 = busy
//  quotient      output  N_BITS_A  signed quotient, truncated toward zero
//  remainder     output  N_BITS_B  signed remainder, same sign as a (or 0)
//  div_by_zero   output  1         b was 0 for the last operation
//  overflow      output  1         a = -2^(N_BITS_A-1) and b = -1 for the last operation
//
// BEHAVIOUR
//  - Reset (async, any state, including mid-operation):
//    - state=IDLE, data_ready=1.
//    - quotient, remainder, div_by_zero and overflow = 0.
//    - The operation in flight is discarded.
//  - FSM states: IDLE, RUN, FIX.
//  - IDLE, start=1 on a clock edge:
//    - Latch sign(a), sign(b), |a| (N_BITS_A+1 bits) and |b|.
//    - Clear the partial remainder; load bit counter = N_BITS_A.
//    - Clear div_by_zero and overflow; data_ready falls the next cycle.
//  - IDLE, start=1 with b=0:
//    - No RUN; go directly to FIX.
//    - FIX sets div_by_zero=1, quotient = all ones, remainder = 0.
//  - RUN: one cycle per quotient bit, N_BITS_A cycles.
//    - Shift the partial remainder left, bringing in the next MSB of |a|.
//    - If partial >= |b|: subtract |b| and shift in quotient bit 1; else shift in 0.
//    - Counter decrements; when it hits 0, go to FIX.
//  - FIX: one cycle.
//    - Negate the quotient if sign(a) xor sign(b).
//    - Negate the remainder if sign(a).
//    - Register the outputs; go to IDLE.
//  - a = -2^(N_BITS_A-1), b = -1:
//    - quotient wraps to -2^(N_BITS_A-1), remainder = 0, overflow=1.
//  - Latency: start edge -> data_ready=1 with valid outputs after N_BITS_A+2 edges
//    (2 edges when b=0).
//  - Outputs hold their values until FIX of the next operation; they do not change during RUN.
//  - start while data_ready=0 is ignored: no queueing, operands not re-sampled.
//  - start asserted in the first data_ready=1 cycle begins the next division:
//    - That same cycle, results are still readable (full throughput).
//  - Arithmetic widths:
//    - Magnitudes use N_BITS_A+1 bits, so |-2^(N_BITS_A-1)| is exact.
//    - Partial remainder uses N_BITS_B+1 bits.
//    - b is sign-extended internally where compared against a.
//  - No early termination; latency is data-independent except for b=0.
//
// TESTING  (N_BITS_A=8, N_BITS_B=8)
//  1. a=100, b=7, start 1 cycle -> after 10 edges data_ready=1,
//     quotient=14, remainder=2, flags 0.
//  2. Sign combinations:
//     - a=-100, b=7  -> q=-14, r=-2
//     - a=100, b=-7  -> q=-14, r=2
//     - a=-100, b=-7 -> q=14, r=-2
//  3. Divide by zero: a=5, b=0 -> data_ready=1 after 2 edges,
//     div_by_zero=1, q=8'hFF, r=0.
//  4. Overflow: a=-128, b=-1 -> q=-128, r=0, overflow=1.
//     Also a=-128, b=1 -> q=-128, overflow=0.
//  5. Back-to-back and ignored start:
//     - 100/7, then 50/5 started the cycle data_ready rises -> 14/2 then 10/0.
//     - start pulsed mid-RUN with new operands -> ignored, first result unchanged.
//  6. Reset mid-operation: reset low during RUN of 100/7 -> outputs 0, data_ready=1 immediately.
//     After release, 9/3 -> q=3, r=0.

Source files
------------

// File: rtl/serial_div.sv
// Serial restoring divider for signed operands: one quotient bit per clock,
// start/data_ready handshake, truncating quotient and remainder signed like a.
module serial_div #(
    parameter int N_BITS_A = 8,
    parameter int N_BITS_B = 8
) (
    input  logic                reset,
    input  logic                clk,
    input  logic [N_BITS_A-1:0] a,
    input  logic [N_BITS_B-1:0] b,
    input  logic                start,
    output logic                data_ready,
    output logic [N_BITS_A-1:0] quotient,
    output logic [N_BITS_B-1:0] remainder,
    output logic                div_by_zero,
    output logic                overflow
);

    localparam int CW = $clog2(N_BITS_A + 1);
    localparam logic [N_BITS_A:0] A_MIN_MAG = {2'b01, {(N_BITS_A-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t              state_reg;
    logic [CW-1:0]       count_reg;
    logic [N_BITS_A-1:0] work_reg;     // |a| shifts out the top, quotient bits shift in
    logic [N_BITS_B:0]   partial_reg;
    logic [N_BITS_B:0]   abs_b_reg;
    logic                sign_a_reg;
    logic                neg_q_reg;
    logic                zero_reg;
    logic                ovf_reg;

    logic [N_BITS_A:0]   a_ext, abs_a;
    logic [N_BITS_B:0]   b_ext, abs_b;
    logic [N_BITS_B+1:0] shifted, diff;
    logic                fits, start_ovf;

    always_comb begin
        a_ext     = {a[N_BITS_A-1], a};
        abs_a     = a[N_BITS_A-1] ? -a_ext : a_ext;
        b_ext     = {b[N_BITS_B-1], b};
        abs_b     = b[N_BITS_B-1] ? -b_ext : b_ext;
        // Only the most negative dividend has magnitude 2^(N-1)
        start_ovf = (abs_a == A_MIN_MAG) && (b == {N_BITS_B{1'b1}});
        shifted   = {partial_reg, work_reg[N_BITS_A-1]};
        diff      = shifted - {1'b0, abs_b_reg};
        fits      = ~diff[N_BITS_B+1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            work_reg    <= '0;
            partial_reg <= '0;
            abs_b_reg   <= '0;
            sign_a_reg  <= 1'b0;
            neg_q_reg   <= 1'b0;
            zero_reg    <= 1'b0;
            ovf_reg     <= 1'b0;
            data_ready  <= 1'b1;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        sign_a_reg  <= a[N_BITS_A-1];
                        neg_q_reg   <= a[N_BITS_A-1] ^ b[N_BITS_B-1];
                        work_reg    <= abs_a[N_BITS_A-1:0];
                        abs_b_reg   <= abs_b;
                        partial_reg <= '0;
                        count_reg   <= CW'(N_BITS_A);
                        zero_reg    <= (b == '0);
                        ovf_reg     <= start_ovf;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        data_ready  <= 1'b0;
                        state_reg   <= (b == '0) ? FIX : RUN;
                    end
                end
                RUN: begin
                    partial_reg <= fits ? diff[N_BITS_B:0] : shifted[N_BITS_B:0];
                    work_reg    <= {work_reg[N_BITS_A-2:0], fits};
                    count_reg   <= count_reg - CW'(1);
                    if (count_reg == CW'(1))
                        state_reg <= FIX;
                end
                FIX: begin
                    if (zero_reg) begin
                        quotient  <= '1;
                        remainder <= '0;
                    end else begin
                        quotient  <= neg_q_reg ? -work_reg : work_reg;
                        remainder <= sign_a_reg ? -partial_reg[N_BITS_B-1:0]
                                                : partial_reg[N_BITS_B-1:0];
                    end
                    div_by_zero <= zero_reg;
                    overflow    <= ovf_reg;
                    data_ready  <= 1'b1;
                    state_reg   <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_div.sv
// Bench for serial_div: directed sign/boundary cases, handshake and reset
// behaviour, then randomized operands checked against integer arithmetic.
module tb_serial_div;

    logic       reset;
    logic       clk;
    logic [7:0] a;
    logic [7:0] b;
    logic       start;
    logic       data_ready;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    logic [7:0] prev_q;

    serial_div #(.N_BITS_A(8), .N_BITS_B(8)) dut (
        .reset      (reset),
        .clk        (clk),
        .a          (a),
        .b          (b),
        .start      (start),
        .data_ready (data_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: plain signed integer division, truncating toward zero
    task automatic model(input logic [7:0] ma, input logic [7:0] mb,
                         output logic [7:0] q, output logic [7:0] r,
                         output logic dz, output logic ov);
        int ai, bi;
        ai = int'($signed(ma));
        bi = int'($signed(mb));
        dz = 1'b0;
        ov = 1'b0;
        if (bi == 0) begin
            q  = 8'hFF;
            r  = 8'h00;
            dz = 1'b1;
        end else if (ai == -128 && bi == -1) begin
            q  = 8'h80;
            r  = 8'h00;
            ov = 1'b1;
        end else begin
            q = 8'(ai / bi);
            r = 8'(ai % bi);
        end
    endtask

    // Called on a negedge with data_ready expected high; returns on the
    // negedge where data_ready is seen high again.
    task automatic do_div(input logic [7:0] ta, input logic [7:0] tb_v, input int pulse_at);
        logic [7:0] eq, er;
        logic       edz, eov;
        int         edges;
        model(ta, tb_v, eq, er, edz, eov);
        check("ready_before", int'(data_ready), 1);
        a = ta;
        b = tb_v;
        start = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", int'(data_ready), 0);
        while (!data_ready && edges < 40) begin
            check("hold_q", int'(quotient), int'(prev_q));
            if (edges == pulse_at) begin
                start = 1'b1;
                a = 8'd50;
                b = 8'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            edges++;
        end
        start = 1'b0;
        check("latency", edges, (tb_v == 8'd0) ? 2 : 10);
        check("quotient", int'(quotient), int'(eq));
        check("remainder", int'(remainder), int'(er));
        check("div_by_zero", int'(div_by_zero), int'(edz));
        check("overflow", int'(overflow), int'(eov));
        prev_q = eq;
        $display("div a=%0d b=%0d -> q=%0d r=%0d dz=%0d ov=%0d lat=%0d",
                 $signed(ta), $signed(tb_v), $signed(quotient), $signed(remainder),
                 div_by_zero, overflow, edges);
    endtask

    initial begin
        logic [7:0] ra, rb;
        int         sel;
        reset = 1'b0;
        start = 1'b0;
        a = 8'd0;
        b = 8'd0;
        prev_q = 8'd0;
        repeat (2) @(negedge clk);
        check("rst_ready", int'(data_ready), 1);
        check("rst_q", int'(quotient), 0);
        check("rst_r", int'(remainder), 0);
        check("rst_dz", int'(div_by_zero), 0);
        check("rst_ov", int'(overflow), 0);
        reset = 1'b1;
        @(negedge clk);

        // Sign combinations, divide by zero, overflow boundary
        do_div(8'd100, 8'd7, 0);
        do_div(8'(-100), 8'd7, 0);
        do_div(8'd100, 8'(-7), 0);
        do_div(8'(-100), 8'(-7), 0);
        do_div(8'd5, 8'd0, 0);
        do_div(8'h80, 8'hFF, 0);
        do_div(8'h80, 8'd1, 0);

        // Back-to-back: next start in the first ready cycle
        do_div(8'd100, 8'd7, 0);
        do_div(8'd50, 8'd5, 0);

        // Start pulsed mid-run with new operands must be ignored
        do_div(8'd100, 8'd7, 3);

        // Asynchronous reset in the middle of a run
        a = 8'd100;
        b = 8'd7;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_ready", int'(data_ready), 1);
        check("midrst_q", int'(quotient), 0);
        check("midrst_r", int'(remainder), 0);
        check("midrst_dz", int'(div_by_zero), 0);
        check("midrst_ov", int'(overflow), 0);
        @(negedge clk);
        reset = 1'b1;
        prev_q = 8'd0;
        @(negedge clk);
        do_div(8'd9, 8'd3, 0);

        // Randomized operands with occasional boundary forcing and idle gaps
        for (int i = 0; i < 150; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            sel = int'($urandom_range(0, 9));
            if (sel == 0) rb = 8'd0;
            if (sel == 1) rb = 8'hFF;
            if (sel == 2) ra = 8'h80;
            if (sel == 3) rb = 8'h80;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_div(ra, rb, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
